control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hardwired control unit that generates the datapath bus-in/bus-out strobes for each instruction.
- Replaces the bench-driven T0..T5 stepping: it runs fetch T0-T2, then executes register-register ALU and shift instructions in T3-T5.
- Sits beside the datapath and the memory interface.
- Register selection goes out as gra/grb/grc plus rin/rout; the select/encode logic in the datapath decodes them into r0i..r15o.

Parameters:
- MEM_TIMEOUT, 15: max cycles to wait for mem_ready in T1W before raising fault.
- TW, 4: width of the wait counter; must satisfy 2^TW > MEM_TIMEOUT.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = keep fetching, 0 = stop at the next instruction boundary.
- mem_ready  in  1  memory read data valid on mdr input this cycle.
- ir  in  32  instruction register contents; opcode ir[31:27].
- pco, mari, inc_pc, zi, zlo_o, pci, read, mdri, mdro, iri, ryi  out  1 each  datapath strobes.
- gra, grb, grc  out  1 each  register-field select (ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]).
- rin, rout  out  1 each  write/drive the selected register.
- alu_op  out  4  ALU function; 4'h0 when not in T4.
- done  out  1  one-cycle pulse in the last cycle of each retired instruction.
- illegal  out  1  one-cycle pulse in T2 when the opcode is undefined.
- halted  out  1  level; 1 while in HALT.
- fault  out  1  sticky; set on memory timeout, cleared only by clear.

Behaviour:
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, HALT, held in a 4-bit state register.
- Outputs are Moore, decoded from the state register only; every output is 0 in IDLE.
- Reset (clear=0, any time, including mid-instruction): state=IDLE, wait counter=0, fault=0; all outputs 0 immediately.
- IDLE: go to T0 when run=1, else stay.
- T0: pco, mari, inc_pc, zi. Next state T1.
- T1: zlo_o, pci, read. Exactly one cycle so PC is loaded once. Next state T1W.
- T1W: read and mdri held.
  - mem_ready=1: next state T2, counter cleared.
  - mem_ready=0: counter increments.
  - Counter reaches MEM_TIMEOUT with mem_ready still 0: set fault and go to HALT.
  - mem_ready=1 in the same cycle the timeout is reached: the ready wins (go to T2, no fault).
- T2: mdro, iri. Next state is decoded from ir in the following cycle (T3 sees the new IR):
  - ALU/shift opcodes go to T3.
  - nop: done=1 in T2, then the boundary rule.
  - halt: go to HALT.
  - undefined opcode: illegal=1 and done=1, treated as nop.
- Opcodes (ir[31:27]) -> alu_op:
  - 00000 add->0, 00001 sub->1, 00010 and->2, 00011 or->3
  - 00100 shr->4, 00101 shl->5, 00110 shra->6, 00111 ror->7, 01000 rol->8
  - 11010 nop; 11011 halt.
- T3: grb, rout, ryi (Y <= R[rb]). Next state T4.
- T4: grc, rout, zi, alu_op = decoded code. For shifts, R[rc] supplies the shift count; the ALU uses its low 5 bits. Next state T5.
- T5: zlo_o, gra, rin (R[ra] <= Zlow), done=1.
- Boundary rule (after T5 or a nop/illegal T2): run=1 goes to T0; run=0 goes to IDLE. run is sampled only at boundaries; dropping run mid-instruction does not abort it.
- HALT: halted=1, absorbing; exits only via clear.
- One strobe set per state; no output is ever asserted in two consecutive states unless listed for both (read and mdri in T1W).

Test Plan:
- Reset mid-T4 of an add: assert clear=0 -> all outputs 0 in the same cycle. Release with run=1 -> pco=1 on the first edge after release.
- shra: ir=32'h3008_8000 (op 00110, ra=0, rb=1, rc=1), mem_ready on the first T1W cycle -> states T0,T1,T1W,T2,T3,T4,T5 in 7 cycles. T4 shows alu_op=6 with grc=1. T5 shows done=1, gra=1, rin=1. With R1=32'hF000_0002 and R1 also holding the count, the datapath result matches the ALU model.
- Memory wait: mem_ready delayed 3 cycles -> T1W lasts 4 cycles, read=1 throughout, pci=1 only in T1. With MEM_TIMEOUT=15 and mem_ready never asserted -> fault=1 and halted=1 after 15 T1W cycles.
- Illegal opcode 5'b10101 -> illegal=1 and done=1 in T2, T3 never entered, next state T0 with run=1.
- run dropped during T3 of an and (op 00010) -> instruction completes with alu_op=2 in T4 and done in T5, then IDLE. Re-raising run -> T0.
- Halt opcode 11011 -> HALT, halted=1; toggling run has no effect; clear=0 returns to IDLE.

Source files
------------

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute control sequencer
//   clock      : system clock, rising edge
//   clear      : asynchronous active-low reset
//   run        : keep fetching; sampled only at instruction boundaries
//   mem_ready  : memory read data valid this cycle
//   ir         : instruction register, opcode ir[31:27]
//   pco..ryi   : datapath bus strobes
//   gra/grb/grc, rin/rout : register-field select and read/write strobes
//   alu_op     : ALU function during T4, else 0
//   done       : last cycle of a retired instruction
//   illegal    : undefined opcode seen in T2
//   halted     : level while in HALT
//   fault      : sticky memory-timeout flag
module control_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        pco,
  output logic        mari,
  output logic        inc_pc,
  output logic        zi,
  output logic        zlo_o,
  output logic        pci,
  output logic        read,
  output logic        mdri,
  output logic        mdro,
  output logic        iri,
  output logic        ryi,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic [3:0]  alu_op,
  output logic        done,
  output logic        illegal,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [4:0]    OP_NOP   = 5'b11010;
  localparam logic [4:0]    OP_HALT  = 5'b11011;
  localparam logic [4:0]    OP_LAST  = 5'b01000;
  // Last T1W cycle before the timeout fires: the counter starts at 0 on the
  // first wait cycle, so MEM_TIMEOUT cycles have elapsed when it reads this.
  localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] wait_cnt;
  logic          fault_q;

  logic [4:0] opcode;
  logic       is_alu;
  logic       is_halt;
  logic       is_nop;
  logic       is_undef;
  logic       timeout_hit;
  logic       unused_ir;

  assign opcode      = ir[31:27];
  assign is_alu      = (opcode <= OP_LAST);
  assign is_halt     = (opcode == OP_HALT);
  assign is_nop      = (opcode == OP_NOP);
  assign is_undef    = !(is_alu || is_halt || is_nop);
  assign timeout_hit = (wait_cnt == WAIT_LAST);
  // Register fields are decoded by the datapath select logic, not here.
  assign unused_ir   = ^ir[26:0];

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Memory wait counter and sticky fault
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (state == S_T1W && !mem_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (state == S_T1W && !mem_ready && timeout_hit) begin
        fault_q <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: next_state = run ? S_T0 : S_IDLE;
      S_T0:   next_state = S_T1;
      S_T1:   next_state = S_T1W;
      S_T1W: begin
        // A ready arriving on the timeout cycle still completes the fetch.
        if (mem_ready)        next_state = S_T2;
        else if (timeout_hit) next_state = S_HALT;
        else                  next_state = S_T1W;
      end
      S_T2: begin
        if (is_alu)       next_state = S_T3;
        else if (is_halt) next_state = S_HALT;
        else              next_state = run ? S_T0 : S_IDLE;
      end
      S_T3:   next_state = S_T4;
      S_T4:   next_state = S_T5;
      S_T5:   next_state = run ? S_T0 : S_IDLE;
      S_HALT: next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    pco     = 1'b0;
    mari    = 1'b0;
    inc_pc  = 1'b0;
    zi      = 1'b0;
    zlo_o   = 1'b0;
    pci     = 1'b0;
    read    = 1'b0;
    mdri    = 1'b0;
    mdro    = 1'b0;
    iri     = 1'b0;
    ryi     = 1'b0;
    gra     = 1'b0;
    grb     = 1'b0;
    grc     = 1'b0;
    rin     = 1'b0;
    rout    = 1'b0;
    alu_op  = 4'h0;
    done    = 1'b0;
    illegal = 1'b0;
    halted  = 1'b0;
    case (state)
      S_T0: begin
        pco    = 1'b1;
        mari   = 1'b1;
        inc_pc = 1'b1;
        zi     = 1'b1;
      end
      S_T1: begin
        zlo_o = 1'b1;
        pci   = 1'b1;
        read  = 1'b1;
      end
      S_T1W: begin
        read = 1'b1;
        mdri = 1'b1;
      end
      S_T2: begin
        mdro    = 1'b1;
        iri     = 1'b1;
        // Undefined opcodes retire as nops.
        done    = is_nop || is_undef;
        illegal = is_undef;
      end
      S_T3: begin
        grb  = 1'b1;
        rout = 1'b1;
        ryi  = 1'b1;
      end
      S_T4: begin
        grc    = 1'b1;
        rout   = 1'b1;
        zi     = 1'b1;
        alu_op = is_alu ? opcode[3:0] : 4'h0;
      end
      S_T5: begin
        zlo_o = 1'b1;
        gra   = 1'b1;
        rin   = 1'b1;
        done  = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign fault = fault_q;

endmodule
